spi_burst_sequencer: RTL and testbench
======================================

Name: spi_burst_sequencer

Overview:
- Sits directly upstream of the per-memory SPI memory manager instances.
- Accepts decoded SPI burst commands (memory code, start address, message count) plus write-data / read-data streams.
- Turns each burst into single-cycle program_memory_new / read_memory_sync strobes with an auto-incrementing message address.
- Captures read data returned on spi_data_out for the SPI transmit path.

Parameters:
- START_ADDRESS_BIT_WIDTH, 14: width of message-granular address driven to memory managers.
- MESSAGE_BIT_WIDTH, 32: SPI message width.
- CODE_BIT_WIDTH, 4: memory-select code width; each memory manager decodes its own is_code_for_this_memory from memory_code.
- LENGTH_BIT_WIDTH, 10: burst length field width.

Ports:
- Clocking and reset:
  - clk  input  1  single clock.
  - rst  input  1  asynchronous, active-high reset.
- Command channel:
  - cmd_valid  input  1  command present.
  - cmd_ready  output  1  sequencer idle, command accepted when cmd_valid&cmd_ready.
  - cmd_is_write  input  1  1 = program burst, 0 = read burst.
  - cmd_code  input  CODE_BIT_WIDTH  target memory code.
  - cmd_start_address  input  START_ADDRESS_BIT_WIDTH  first message address.
  - cmd_length  input  LENGTH_BIT_WIDTH  messages in burst minus one.
- Write-data channel:
  - wr_data_valid  input  1  write message present.
  - wr_data_ready  output  1  sequencer takes write message.
  - wr_data  input  MESSAGE_BIT_WIDTH  write message.
- Read-data channel:
  - rd_data_valid  output  1  read message held for SPI transmit.
  - rd_data_ready  input  1  SPI transmit consumed rd_data.
  - rd_data  output  MESSAGE_BIT_WIDTH  captured read message.
- Memory-manager side:
  - program_memory_new  output  1  one-cycle write strobe.
  - read_memory_sync  output  1  one-cycle read strobe.
  - memory_code  output  CODE_BIT_WIDTH  registered target code.
  - spi_address  output  START_ADDRESS_BIT_WIDTH  current message address.
  - spi_data_in  output  MESSAGE_BIT_WIDTH  registered write message.
  - spi_data_out  input  MESSAGE_BIT_WIDTH  read data from addressed memory manager, valid the cycle after read_memory_sync.
- Status:
  - busy  output  1  burst in progress.
  - burst_done  output  1  one-cycle pulse on completion of the last message.

Behaviour:
- Reset (asynchronous, any state, including mid-burst): state IDLE.
  - All outputs 0, except cmd_ready=1.
  - Remaining-count and address registers cleared.
  - An in-flight strobe is dropped; no partial burst resumes.
- All outputs are registered, except cmd_ready, wr_data_ready and busy, which decode the current state.
- States and transitions:
  - IDLE:
    - cmd_ready=1.
    - On accept: latch code, start address and remaining=cmd_length.
    - Go to WR_WAIT if cmd_is_write, else RD_ISSUE.
  - WR_WAIT:
    - wr_data_ready=1.
    - On wr_data_valid: latch spi_data_in<=wr_data, go to WR_ISSUE.
  - WR_ISSUE:
    - program_memory_new=1 for exactly one cycle with stable spi_address, spi_data_in and memory_code.
    - Next cycle: if remaining==0, go to IDLE with burst_done=1.
    - Otherwise: address+1, remaining-1, go to WR_WAIT.
  - RD_ISSUE: read_memory_sync=1 for exactly one cycle, go to RD_CAPTURE.
  - RD_CAPTURE: rd_data<=spi_data_out, rd_data_valid<=1, go to RD_HOLD.
  - RD_HOLD:
    - rd_data and rd_data_valid stay stable until rd_data_ready.
    - On rd_data_ready: rd_data_valid<=0.
    - If remaining==0: go to IDLE with burst_done=1.
    - Otherwise: address+1, remaining-1, go to RD_ISSUE.
- Read-request-to-rd_data_valid latency: 2 cycles.
- Write throughput: at most one message per 2 cycles.
- Address increments modulo 2^START_ADDRESS_BIT_WIDTH; all-ones wraps to 0 without error.
- cmd_length=0 gives a one-message burst. Maximum burst is 2^LENGTH_BIT_WIDTH messages.
- busy=1 in every state except IDLE.
- cmd_ready=0 while busy; commands presented then are not consumed.
- program_memory_new and read_memory_sync are never high in the same cycle.
- memory_code and spi_address hold their values between strobes and after burst end, until the next command.

Optional Feature:
- Macro: SPI_BURST_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort high at a clock edge in any non-IDLE state returns to IDLE next cycle.
  - Clears rd_data_valid, suppresses any strobe not yet issued, and pulses burst_done=0.
  - Adds output aborted: one-cycle pulse on that transition.
  - abort is ignored in IDLE.
- When undefined: no abort or aborted port; bursts always run to completion.

Test Plan:
- Write burst: code=3, start=0x0010, length=2, data 0xA, 0xB, 0xC with wr_data_valid always high -> three program_memory_new pulses at addresses 0x0010/0x0011/0x0012 carrying 0xA/0xB/0xC. memory_code=3 throughout. burst_done one cycle after the third strobe.
- Read burst with model memory returning address+0x100 one cycle after read_memory_sync: start=0x0020, length=1 -> rd_data 0x120 then 0x121. rd_data_valid 2 cycles after each strobe.
- Read backpressure: rd_data_ready held low 5 cycles -> rd_data stable, no further read_memory_sync until ready asserted.
- Wrap: start=0x3FFF, length=1, write -> strobes at 0x3FFF then 0x0000.
- Reset mid-burst: assert rst during WR_WAIT of message 2 of 4 -> all outputs 0 and cmd_ready=1 immediately. Next command starts cleanly at its own start address.
- With SPI_BURST_ABORT_EN: abort during RD_HOLD -> next cycle IDLE, rd_data_valid=0, aborted pulse, no burst_done.

Source files
------------

// File: rtl/spi_burst_sequencer.sv
// ============================================================================
// Module      : spi_burst_sequencer
// Description : Expands SPI burst commands into single-cycle program/read
//               strobes with an auto-incrementing message address, and
//               captures returned read data for the SPI transmit path.
//               Optional abort support is compiled in with SPI_BURST_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_burst_sequencer #(
    parameter int START_ADDRESS_BIT_WIDTH = 14,
    parameter int MESSAGE_BIT_WIDTH       = 32,
    parameter int CODE_BIT_WIDTH          = 4,
    parameter int LENGTH_BIT_WIDTH        = 10
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef SPI_BURST_ABORT_EN
    input  logic                               abort,
    output logic                               aborted,
`endif
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_is_write,
    input  logic [CODE_BIT_WIDTH-1:0]          cmd_code,
    input  logic [START_ADDRESS_BIT_WIDTH-1:0] cmd_start_address,
    input  logic [LENGTH_BIT_WIDTH-1:0]        cmd_length,
    input  logic                               wr_data_valid,
    output logic                               wr_data_ready,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       wr_data,
    output logic                               rd_data_valid,
    input  logic                               rd_data_ready,
    output logic [MESSAGE_BIT_WIDTH-1:0]       rd_data,
    output logic                               program_memory_new,
    output logic                               read_memory_sync,
    output logic [CODE_BIT_WIDTH-1:0]          memory_code,
    output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
    output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out,
    output logic                               busy,
    output logic                               burst_done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_WAIT    = 3'd1,
        S_WR_ISSUE   = 3'd2,
        S_RD_ISSUE   = 3'd3,
        S_RD_CAPTURE = 3'd4,
        S_RD_HOLD    = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [LENGTH_BIT_WIDTH-1:0] r_remaining;
    logic                        w_abort;
    logic                        w_accept;
    logic                        w_wr_take;
    logic                        w_advance;
    logic                        w_last;

`ifdef SPI_BURST_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign wr_data_ready = (r_state == S_WR_WAIT);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_wr_take    = 1'b0;
        w_advance    = 1'b0;
        w_last       = (r_remaining == '0);
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = cmd_is_write ? S_WR_WAIT : S_RD_ISSUE;
                end
            end
            S_WR_WAIT: begin
                if (wr_data_valid) begin
                    w_wr_take    = 1'b1;
                    w_state_next = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                w_advance    = 1'b1;
                w_state_next = w_last ? S_IDLE : S_WR_WAIT;
            end
            S_RD_ISSUE:   w_state_next = S_RD_CAPTURE;
            S_RD_CAPTURE: w_state_next = S_RD_HOLD;
            S_RD_HOLD: begin
                if (rd_data_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last ? S_IDLE : S_RD_ISSUE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Abort overrides every transition, so no new strobe or data capture follows it.
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_wr_take    = 1'b0;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes are registered from the next state so they coincide exactly with the ISSUE states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            program_memory_new <= 1'b0;
            read_memory_sync   <= 1'b0;
            burst_done         <= 1'b0;
            rd_data_valid      <= 1'b0;
            rd_data            <= '0;
            memory_code        <= '0;
            spi_address        <= '0;
            spi_data_in        <= '0;
            r_remaining        <= '0;
        end else begin
            program_memory_new <= (w_state_next == S_WR_ISSUE);
            read_memory_sync   <= (w_state_next == S_RD_ISSUE);
            burst_done         <= w_advance && w_last;
            rd_data_valid      <= (w_state_next == S_RD_HOLD);
            if (r_state == S_RD_CAPTURE && !w_abort) begin
                rd_data <= spi_data_out;
            end
            if (w_accept) begin
                memory_code <= cmd_code;
                spi_address <= cmd_start_address;
                r_remaining <= cmd_length;
            end
            if (w_wr_take) begin
                spi_data_in <= wr_data;
            end
            if (w_advance && !w_last) begin
                spi_address <= spi_address + START_ADDRESS_BIT_WIDTH'(1);
                r_remaining <= r_remaining - LENGTH_BIT_WIDTH'(1);
            end
        end
    end

`ifdef SPI_BURST_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted <= 1'b0;
        end else begin
            aborted <= w_abort;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_sequencer.sv
// ============================================================================
// Module      : tb_spi_burst_sequencer
// Description : Directed scoreboard bench for spi_burst_sequencer, with a
//               model memory answering reads with address + 0x100.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_write = 1'b0;
    logic [3:0]  cmd_code = '0;
    logic [13:0] cmd_start_address = '0;
    logic [9:0]  cmd_length = '0;
    logic        wr_data_valid = 1'b0;
    logic        wr_data_ready;
    logic [31:0] wr_data = '0;
    logic        rd_data_valid;
    logic        rd_data_ready = 1'b1;
    logic [31:0] rd_data;
    logic        program_memory_new;
    logic        read_memory_sync;
    logic [3:0]  memory_code;
    logic [13:0] spi_address;
    logic [31:0] spi_data_in;
    logic [31:0] spi_data_out = '0;
    logic        busy;
    logic        burst_done;
`ifdef SPI_BURST_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    spi_burst_sequencer dut (
        .clk               (clk),
        .rst               (rst),
`ifdef SPI_BURST_ABORT_EN
        .abort             (abort),
        .aborted           (aborted),
`endif
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_is_write      (cmd_is_write),
        .cmd_code          (cmd_code),
        .cmd_start_address (cmd_start_address),
        .cmd_length        (cmd_length),
        .wr_data_valid     (wr_data_valid),
        .wr_data_ready     (wr_data_ready),
        .wr_data           (wr_data),
        .rd_data_valid     (rd_data_valid),
        .rd_data_ready     (rd_data_ready),
        .rd_data           (rd_data),
        .program_memory_new(program_memory_new),
        .read_memory_sync  (read_memory_sync),
        .memory_code       (memory_code),
        .spi_address       (spi_address),
        .spi_data_in       (spi_data_in),
        .spi_data_out      (spi_data_out),
        .busy              (busy),
        .burst_done        (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  code;
    } wr_exp_t;

    wr_exp_t     exp_wr[$];
    logic [31:0] exp_rd[$];
    int          rs_q[$];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          done_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_adv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (read_memory_sync) spi_data_out <= 32'(spi_address) + 32'h100;
    end

    always @(negedge clk) begin
        if (!rst) begin
            wr_exp_t e;
            if (program_memory_new || read_memory_sync)
                chk("strobe_exclusive", 64'(program_memory_new & read_memory_sync), 0);
            if (program_memory_new) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(spi_address), 64'(e.addr));
                    chk("wr_data", 64'(spi_data_in), 64'(e.data));
                    chk("wr_code", 64'(memory_code), 64'(e.code));
                end
            end
            if (read_memory_sync) rs_q.push_back(cyc);
            if (rd_data_valid && !prev_valid) begin
                if (rs_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
                else chk("rd_latency", 64'(cyc - rs_q.pop_front()), 2);
            end
            if (rd_data_valid && rd_data_ready) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
            end
            if (burst_done) begin
                done_cnt++;
                chk("done_after_last", 64'(prev_adv), 1);
            end
            prev_valid = rd_data_valid;
            prev_adv   = program_memory_new || (rd_data_valid && rd_data_ready);
        end else begin
            prev_valid = 1'b0;
            prev_adv   = 1'b0;
        end
    end

    // All drive tasks start and end at the posedge+#1 phase.
    task automatic send_cmd(input logic wr, input logic [3:0] code,
                            input logic [13:0] start, input logic [9:0] len);
        int n = 0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b1; cmd_is_write = wr; cmd_code = code;
        cmd_start_address = start; cmd_length = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", {63'b0, busy}, 1);
        chk("cmd_ready_while_busy", {63'b0, cmd_ready}, 0);
    endtask

    task automatic push_writes(input logic [3:0] code, input logic [13:0] start,
                               input logic [31:0] d0, input int cnt);
        logic [13:0] a = start;
        for (int i = 0; i < cnt; i++) begin
            exp_wr.push_back('{addr: a, data: d0 + 32'(i), code: code});
            a = a + 14'd1;
        end
    endtask

    task automatic feed_word(input logic [31:0] d);
        int n = 0;
        wr_data_valid = 1'b1; wr_data = d;
        while (!wr_data_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("wr_ready_timeout", {63'b0, wr_data_ready}, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 500 && busy; n++) @(negedge clk);
        chk("idle_timeout", {63'b0, busy}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] held;
        int          sc;
        int          dc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'b0, cmd_ready}, 1);
        chk("rst_busy", {63'b0, busy}, 0);
        chk("rst_strobes", {62'b0, program_memory_new, read_memory_sync}, 0);
        chk("rst_addr_code", {46'b0, spi_address, memory_code}, 0);
        chk("rst_rd_valid_done", {62'b0, rd_data_valid, burst_done}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write burst of three with data always available.
        push_writes(4'd3, 14'h0010, 32'hA, 3);
        send_cmd(1'b1, 4'd3, 14'h0010, 10'd2);
        for (int i = 0; i < 3; i++) feed_word(32'hA + 32'(i));
        wr_data_valid = 1'b0;
        wait_idle();
        chk("wr_done_count", 64'(done_cnt), 1);
        chk("wr_code_hold", 64'(memory_code), 3);
        chk("wr_addr_hold", 64'(spi_address), 64'h12);
        chk("wr_queue_empty", 64'(exp_wr.size()), 0);

        // Read burst of two, consumer always ready.
        exp_rd.push_back(32'h120); exp_rd.push_back(32'h121);
        send_cmd(1'b0, 4'd5, 14'h0020, 10'd1);
        wait_idle();
        chk("rd_done_count", 64'(done_cnt), 2);
        chk("rd_queue_empty", 64'(exp_rd.size()), 0);

        // Read backpressure: data must hold and no new read issued.
        rd_data_ready = 1'b0;
        exp_rd.push_back(32'h130); exp_rd.push_back(32'h131);
        send_cmd(1'b0, 4'd5, 14'h0030, 10'd1);
        for (int n = 0; n < 20 && !rd_data_valid; n++) @(negedge clk);
        chk("bp_valid_seen", {63'b0, rd_data_valid}, 1);
        held = rd_data;
        sc = 0;
        dc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (read_memory_sync) sc++;
            if (rd_data !== held || !rd_data_valid) dc++;
        end
        chk("bp_no_strobe", 64'(sc), 0);
        chk("bp_data_stable", 64'(dc), 0);
        chk("bp_held_value", 64'(held), 64'h130);
        @(posedge clk); #1;
        rd_data_ready = 1'b1;
        wait_idle();
        chk("bp_queue_empty", 64'(exp_rd.size()), 0);

        // Address wrap at all-ones.
        push_writes(4'd7, 14'h3FFF, 32'h11, 2);
        send_cmd(1'b1, 4'd7, 14'h3FFF, 10'd1);
        feed_word(32'h11);
        feed_word(32'h12);
        wr_data_valid = 1'b0;
        wait_idle();
        chk("wrap_addr_final", 64'(spi_address), 0);
        chk("wrap_queue_empty", 64'(exp_wr.size()), 0);

        // Reset while waiting for the second of four write messages.
        push_writes(4'd2, 14'h0100, 32'h40, 4);
        send_cmd(1'b1, 4'd2, 14'h0100, 10'd3);
        feed_word(32'h40);
        wr_data_valid = 1'b0;
        for (int n = 0; n < 20 && !wr_data_ready; n++) begin @(posedge clk); #1; end
        chk("mid_in_wr_wait", {63'b0, wr_data_ready}, 1);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        exp_wr.delete();
        chk("mid_rst_cmd_ready", {63'b0, cmd_ready}, 1);
        chk("mid_rst_busy_ready", {62'b0, busy, wr_data_ready}, 0);
        chk("mid_rst_addr_code", {46'b0, spi_address, memory_code}, 0);
        chk("mid_rst_data_in", 64'(spi_data_in), 0);
        chk("mid_rst_strobes", {61'b0, program_memory_new, read_memory_sync, burst_done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_writes(4'd9, 14'h0200, 32'h55, 1);
        send_cmd(1'b1, 4'd9, 14'h0200, 10'd0);
        feed_word(32'h55);
        wr_data_valid = 1'b0;
        wait_idle();
        chk("post_rst_addr", 64'(spi_address), 64'h200);
        chk("post_rst_done", 64'(done_cnt - dc), 1);
        chk("post_rst_queue", 64'(exp_wr.size()), 0);

`ifdef SPI_BURST_ABORT_EN
        // Abort while a read is held for the consumer.
        rd_data_ready = 1'b0;
        exp_rd.push_back(32'h140);
        send_cmd(1'b0, 4'd1, 14'h0040, 10'd3);
        for (int n = 0; n < 20 && !rd_data_valid; n++) begin @(posedge clk); #1; end
        chk("ab_valid_seen", {63'b0, rd_data_valid}, 1);
        dc = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_idle", {63'b0, cmd_ready}, 1);
        chk("ab_rd_valid", {63'b0, rd_data_valid}, 0);
        chk("ab_pulse", {63'b0, aborted}, 1);
        chk("ab_no_done", {63'b0, burst_done}, 0);
        @(posedge clk); #1;
        chk("ab_pulse_one_cycle", {63'b0, aborted}, 0);
        chk("ab_done_count", 64'(done_cnt - dc), 0);
        exp_rd.delete();
        rd_data_ready = 1'b1;
`endif

        chk("final_rd_queue", 64'(exp_rd.size()), 0);
        chk("final_strobe_queue", 64'(rs_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
